// File: rtl/ov_cap_pkg.sv
// rtl/ov_cap_pkg.sv - shared types and constants for the OV7670 capture path
package ov_cap_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_INIT = 2'd0,
    ST_SKIP      = 2'd1,
    ST_WAIT_VS   = 2'd2,
    ST_CAPTURE   = 2'd3
  } cap_state_e;

  localparam int RGB565_W     = 16;
  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES  = 480;
  localparam int PIX_CNT_W    = 10;
  localparam int LINE_CNT_W   = 9;
  localparam int SKIP_CNT_W   = 8;

endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - registers the camera bus once and flags VSYNC/HREF edges
module cam_sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       href_r_o,
  output logic [7:0] data_r_o,
  output logic       vs_fall_o,
  output logic       vs_rise_o,
  output logic       hr_fall_o
);

  logic       primed_q;
  logic       vs_q, vs_dly_q;
  logic       hr_q, hr_dly_q;
  logic [7:0] data_q;

  // The delayed copies are seeded from the pins on the first sample so that
  // whatever level the sensor is at when reset releases is not seen as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      vs_q     <= 1'b0;
      vs_dly_q <= 1'b0;
      hr_q     <= 1'b0;
      hr_dly_q <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      primed_q <= 1'b1;
      vs_q     <= vsync_i;
      hr_q     <= href_i;
      data_q   <= data_i;
      vs_dly_q <= primed_q ? vs_q : vsync_i;
      hr_dly_q <= primed_q ? hr_q : href_i;
    end
  end

  assign href_r_o  = hr_q;
  assign data_r_o  = data_q;
  assign vs_fall_o = vs_dly_q & ~vs_q;
  assign vs_rise_o = ~vs_dly_q & vs_q;
  assign hr_fall_o = hr_dly_q & ~hr_q;

endmodule

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 byte stream to RGB565 words for the SDRAM write FIFO
module ov7670_capture
  import ov_cap_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES,
  parameter int SKIP_FRAMES = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdram_init_done,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_data,
  output logic                sys_we,
  output logic [RGB565_W-1:0] sys_data_in,
  output logic                frame_valid,
  output logic                frame_err
);

  localparam logic [PIX_CNT_W-1:0]  H_N    = PIX_CNT_W'(H_PIXELS);
  localparam logic [LINE_CNT_W-1:0] V_N    = LINE_CNT_W'(V_LINES);
  localparam logic [SKIP_CNT_W-1:0] SKIP_N = SKIP_CNT_W'(SKIP_FRAMES);

  logic       hr_r;
  logic [7:0] d_r;
  logic       vs_fall, vs_rise, hr_fall;

  cam_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync_i   (cam_vsync),
    .href_i    (cam_href),
    .data_i    (cam_data),
    .href_r_o  (hr_r),
    .data_r_o  (d_r),
    .vs_fall_o (vs_fall),
    .vs_rise_o (vs_rise),
    .hr_fall_o (hr_fall)
  );

  cap_state_e              state_q, state_d;
  logic [SKIP_CNT_W-1:0]   skip_q, skip_d;
  logic                    phase_q, phase_d;
  logic [7:0]              hi_q, hi_d;
  logic [PIX_CNT_W-1:0]    pix_q, pix_d;
  logic [LINE_CNT_W-1:0]   line_q, line_d;
  logic                    bad_q, bad_d;
  logic                    we_q, we_d;
  logic [RGB565_W-1:0]     data_q, data_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!sdram_init_done) begin
      state_d = ST_WAIT_INIT;
    end else begin
      case (state_q)
        ST_WAIT_INIT: state_d = (SKIP_FRAMES > 0) ? ST_SKIP : ST_WAIT_VS;
        ST_SKIP:      if (vs_rise && (skip_q + 1'b1) == SKIP_N) state_d = ST_WAIT_VS;
        ST_WAIT_VS:   if (vs_fall) state_d = ST_CAPTURE;
        ST_CAPTURE:   if (vs_rise) state_d = ST_WAIT_VS;
        default:      state_d = ST_WAIT_INIT;
      endcase
    end
  end

  always_comb begin
    skip_d  = skip_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    pix_d   = pix_q;
    line_d  = line_q;
    bad_d   = bad_q;
    we_d    = 1'b0;
    data_d  = data_q;
    err_d   = 1'b0;
    fv_d    = (state_d == ST_CAPTURE);
    case (state_q)
      ST_WAIT_INIT: skip_d = '0;
      ST_SKIP:      if (vs_rise) skip_d = skip_q + 1'b1;
      ST_WAIT_VS: begin
        if (vs_fall) begin
          pix_d   = '0;
          line_d  = '0;
          bad_d   = 1'b0;
          phase_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (hr_r) begin
          if (!phase_q) begin
            hi_d    = d_r;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (pix_q != '1) pix_d = pix_q + 1'b1;
            // Overlong lines and surplus lines are counted but never written.
            if (pix_q < H_N && line_q < V_N) begin
              we_d   = 1'b1;
              data_d = {hi_q, d_r};
            end
          end
        end
        if (hr_fall) begin
          if (pix_q != H_N || phase_q || line_q >= V_N) bad_d = 1'b1;
          if (line_q != '1) line_d = line_q + 1'b1;
          pix_d   = '0;
          phase_d = 1'b0;
        end
        // Uses the post-line-check values so a line closing with VSYNC is judged first.
        if (vs_rise && sdram_init_done) err_d = bad_d | (line_d != V_N);
        if (state_d != ST_CAPTURE) phase_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_q  <= '0;
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
      pix_q   <= '0;
      line_q  <= '0;
      bad_q   <= 1'b0;
      we_q    <= 1'b0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      skip_q  <= skip_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      bad_q   <= bad_d;
      we_q    <= we_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign sys_we      = we_q;
  assign sys_data_in = data_q;
  assign frame_valid = fv_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - self-checking bench for ov7670_capture with a frame-level model
module tb_ov7670_capture;

  localparam int H_N    = 8;
  localparam int V_N    = 4;
  localparam int SKIP_N = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sdram_init_done;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        sys_we;
  logic [15:0] sys_data_in;
  logic        frame_valid;
  logic        frame_err;

  ov7670_capture #(
    .H_PIXELS    (H_N),
    .V_LINES     (V_N),
    .SKIP_FRAMES (SKIP_N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .cam_vsync       (cam_vsync),
    .cam_href        (cam_href),
    .cam_data        (cam_data),
    .sys_we          (sys_we),
    .sys_data_in     (sys_data_in),
    .frame_valid     (frame_valid),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];
  int          err_cnt   = 0;
  int          fv_rises  = 0;
  int          frames_seen = 0;
  bit          relax = 1'b0;
  bit          prev_we = 1'b0;
  bit          prev_fv = 1'b0;

  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (sys_we) begin
        got_q.push_back(sys_data_in);
        check("we_spacing", int'(prev_we), 0);
        if (!relax) check("we_in_fv", int'(frame_valid), 1);
      end
      if (frame_valid && !prev_fv) fv_rises++;
      if (frame_err) begin
        err_cnt++;
        check("err_at_fv_fall", int'({prev_fv, frame_valid}), 2);
      end
      prev_we = sys_we;
      prev_fv = frame_valid;
    end else begin
      prev_we = 1'b0;
      prev_fv = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    err_cnt  = 0;
    fv_rises = 0;
  endtask

  // Drives one complete frame and appends to exp_q the words it should yield.
  task automatic run_frame(input int lines, input int sl, input int sb, input bit tight);
    logic [7:0] lb [$];
    bit cap;
    int nb;
    cap = (frames_seen >= SKIP_N);
    cam_vsync = 1'b0;
    tick(); tick();
    for (int l = 0; l < lines; l++) begin
      nb = (l == sl) ? sb : 2 * H_N;
      lb.delete();
      for (int b = 0; b < nb; b++) begin
        logic [7:0] v;
        v = 8'($urandom);
        lb.push_back(v);
        cam_href = 1'b1;
        cam_data = v;
        tick();
      end
      for (int p = 0; p < nb / 2; p++)
        if (cap && p < H_N && l < V_N) exp_q.push_back({lb[2*p], lb[2*p+1]});
      cam_href = 1'b0;
      if (tight && l == lines - 1) cam_vsync = 1'b1;
      tick(); tick(); tick();
    end
    cam_vsync = 1'b1;
    repeat (6) tick();
    frames_seen++;
  endtask

  task automatic check_frame(input string tag, input int ew, input int ee, input int ef);
    int mism;
    mism = 0;
    check({tag, "_strobes"}, got_q.size(), ew);
    check({tag, "_model_len"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      foreach (got_q[i]) if (got_q[i] !== exp_q[i]) mism++;
      check({tag, "_data_mismatches"}, mism, 0);
    end
    check({tag, "_err_pulses"}, err_cnt, ee);
    check({tag, "_fv_windows"}, fv_rises, ef);
    clear_mon();
  endtask

  typedef struct {
    int lines;
    int short_line;
    int short_bytes;
    bit tight;
    int exp_words;
    int exp_err;
    int exp_fv;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{4, -1, 0,  1'b0, 0,  0, 0};
    tbl[1]  = '{4, -1, 0,  1'b0, 0,  0, 0};
    tbl[2]  = '{4, -1, 0,  1'b0, 32, 0, 1};
    tbl[3]  = '{4, -1, 0,  1'b0, 32, 0, 1};
    tbl[4]  = '{4, 1,  14, 1'b0, 31, 1, 1};
    tbl[5]  = '{4, -1, 0,  1'b0, 32, 0, 1};
    tbl[6]  = '{5, -1, 0,  1'b0, 32, 1, 1};
    tbl[7]  = '{4, 2,  15, 1'b0, 31, 1, 1};
    tbl[8]  = '{3, -1, 0,  1'b0, 24, 1, 1};
    tbl[9]  = '{4, 0,  20, 1'b0, 32, 1, 1};
    tbl[10] = '{4, -1, 0,  1'b1, 32, 0, 1};
    tbl[11] = '{4, 3,  12, 1'b1, 30, 1, 1};

    rst_n = 1'b0;
    sdram_init_done = 1'b0;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) tick();
    check("rst_we", int'(sys_we), 0);
    check("rst_data", int'(sys_data_in), 0);
    check("rst_fv", int'(frame_valid), 0);
    check("rst_err", int'(frame_err), 0);
    rst_n = 1'b1;
    tick(); tick();
    sdram_init_done = 1'b1;
    frames_seen = 0;
    tick();
    clear_mon();

    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].lines, tbl[i].short_line, tbl[i].short_bytes, tbl[i].tight);
      check_frame($sformatf("frm%0d", i), tbl[i].exp_words, tbl[i].exp_err, tbl[i].exp_fv);
    end

    // Pixel latency and frame_valid rise timing.
    cam_vsync = 1'b0;
    tick();
    check("fv_not_yet", int'(frame_valid), 0);
    tick();
    check("fv_rise_2cyc", int'(frame_valid), 1);
    cam_href = 1'b1;
    cam_data = 8'hF8;
    tick();
    cam_data = 8'h1F;
    tick();
    check("we_not_early", int'(sys_we), 0);
    cam_href = 1'b0;
    tick();
    check("we_at_n2", int'(sys_we), 1);
    check("word_f81f", int'(sys_data_in), 16'hF81F);
    tick();
    check("we_one_cycle", int'(sys_we), 0);
    check("data_hold", int'(sys_data_in), 16'hF81F);
    cam_vsync = 1'b1;
    repeat (6) tick();
    check("short_frame_err", err_cnt, 1);
    clear_mon();

    // Loss of sdram_init_done mid-line.
    cam_vsync = 1'b0;
    tick(); tick();
    for (int b = 0; b < 6; b++) begin
      cam_href = 1'b1;
      cam_data = 8'($urandom);
      tick();
    end
    relax = 1'b1;
    sdram_init_done = 1'b0;
    cam_data = 8'($urandom);
    tick();
    check("fv_drop_on_init", int'(frame_valid), 0);
    tick();
    n = got_q.size();
    for (int b = 0; b < 10; b++) begin
      cam_data = 8'($urandom);
      tick();
    end
    cam_href = 1'b0;
    tick(); tick(); tick();
    cam_vsync = 1'b1;
    repeat (6) tick();
    check("no_we_after_drop", got_q.size(), n);
    check("no_err_on_drop", err_cnt, 0);
    relax = 1'b0;
    sdram_init_done = 1'b1;
    frames_seen = 0;
    tick();
    clear_mon();
    for (int f = 0; f < 3; f++) begin
      run_frame(4, -1, 0, 1'b0);
      check_frame($sformatf("reinit%0d", f), (f == 2) ? 32 : 0, 0, (f == 2) ? 1 : 0);
    end

    // Asynchronous reset mid-line.
    cam_vsync = 1'b0;
    tick(); tick();
    for (int b = 0; b < 5; b++) begin
      cam_href = 1'b1;
      cam_data = 8'($urandom);
      tick();
    end
    check("fv_before_rst", int'(frame_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", int'(sys_we), 0);
    check("arst_data", int'(sys_data_in), 0);
    check("arst_fv", int'(frame_valid), 0);
    check("arst_err", int'(frame_err), 0);
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    frames_seen = 0;
    clear_mon();
    for (int f = 0; f < 3; f++) begin
      run_frame(4, -1, 0, 1'b0);
      check_frame($sformatf("postrst%0d", f), (f == 2) ? 32 : 0, 0, (f == 2) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side producer for the SDRAM frame buffer write port. It samples the OV7670 byte stream (VSYNC/HREF/D[7:0]), packs byte pairs into RGB565 words, and drives `sys_we`/`sys_data_in`/`frame_valid` into the SDRAM top-level write FIFO. It is the counterpart of the VGA read path: it fills the bank that the bank switcher later hands to the reader. It discards start-up frames, aligns capture to frame boundaries and flags malformed frames.

## Interface
Parameters:
- `H_PIXELS`, 640: RGB565 pixels per line (2 bytes each).
- `V_LINES`, 480: lines per frame.
- `SKIP_FRAMES`, 10: complete frames discarded after `sdram_init_done` rises (sensor settling); 0 is legal.

Ports:
- `clk` in 1: camera pixel clock (PCLK); the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sdram_init_done` in 1: SDRAM controller ready.
- `cam_vsync` in 1: active-high frame sync; high between frames.
- `cam_href` in 1: active-high line valid.
- `cam_data` in 8: pixel byte; high byte first.
- `sys_we` out 1: one-cycle write strobe to the SDRAM write FIFO.
- `sys_data_in` out 16: RGB565 word, `{byte0, byte1}`.
- `frame_valid` out 1: high for the duration of each captured frame.
- `frame_err` out 1: one-cycle pulse at the end of a captured frame whose geometry was wrong.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are registered once (the `_r` signals). All logic below uses the registered copies.
- Edge detects on the registered signals: `vs_fall` (frame start), `vs_rise` (frame end), `hr_fall` (line end).
- FSM states:
  - WAIT_INIT: entered on reset. Leaves when `sdram_init_done` = 1. If `SKIP_FRAMES` > 0 it goes to SKIP with `skip_cnt` = 0, otherwise to WAIT_VS.
  - SKIP: each `vs_rise` increments `skip_cnt`. When the count reaches `SKIP_FRAMES` it goes to WAIT_VS.
  - WAIT_VS: waits for `vs_fall`, then goes to CAPTURE. Any partial frame already in progress is ignored.
  - CAPTURE: captures pixels. On `vs_rise` it runs the end-of-frame check, then returns to WAIT_VS.
  - From any state, `sdram_init_done` = 0 forces WAIT_INIT on the next cycle.
- Byte pairing, CAPTURE only:
  - A `phase` bit toggles on every cycle with `cam_href_r` = 1.
  - phase 0 latches `hi`.
  - phase 1 drives `sys_data_in` = `{hi, cam_data_r}`, asserts `sys_we` for one cycle, and increments `pix_cnt`.
  - `phase` is cleared on `hr_fall`, on `vs_fall` and when leaving CAPTURE.
- Geometry counters, all cleared on `vs_fall`:
  - `pix_cnt`: 10 bits, pixels in the current line. Cleared on `hr_fall`.
  - `line_cnt`: 9 bits, incremented on `hr_fall`.
  - `bad`: sticky flag. Set on `hr_fall` if `pix_cnt` ≠ `H_PIXELS` or `phase` = 1 (odd byte count). Set when `line_cnt` would exceed `V_LINES`.
  - At `vs_rise` in CAPTURE, `frame_err` = `bad` | (`line_cnt` ≠ `V_LINES`).
  - Pixels beyond `H_PIXELS` in a line, or beyond `V_LINES` lines, are not written (`sys_we` is suppressed). The frame still completes.
- `frame_valid`: set on the transition WAIT_VS→CAPTURE. Cleared on CAPTURE exit.

## Timing
- Reset values: `sys_we` = 0, `sys_data_in` = 16'h0000, `frame_valid` = 0, `frame_err` = 0. FSM = WAIT_INIT, all counters and `phase` = 0.
- Latency: second byte at the pins on cycle N → registered at N+1 → `sys_we`/`sys_data_in` valid on cycle N+2.
- `sys_data_in` holds its value between strobes.
- `sys_we` maximum rate: once every 2 cycles. No back-pressure; the FIFO absorbs the rate.
- `frame_valid` rises 2 cycles after VSYNC falls at the pins and falls 2 cycles after VSYNC rises. Every `sys_we` of a frame lies strictly inside its `frame_valid` window.
- `frame_err` is asserted in the same cycle that `frame_valid` falls.
- Simultaneous events:
  - `hr_fall` and `vs_rise` in the same cycle: the line check applies first, then the frame check (both in that cycle).
  - A phase-1 byte and `sdram_init_done` falling in the same cycle: that word is still written. Nothing is written afterwards.
- Reset or init loss mid-frame: `frame_valid` drops within 1 cycle and no `frame_err` pulse is produced. Capture restarts only after a full skip and resync.

## Structure
- Shared package `ov_cap_pkg`: FSM state enum (`ST_WAIT_INIT`, `ST_SKIP`, `ST_WAIT_VS`, `ST_CAPTURE`); RGB565 word width constant; default geometry constants 640/480.
- Sub-module `cam_sync_edge`: registers vsync/href/data and produces `vs_fall`, `vs_rise`, `hr_fall`. The FSM, pairing and checks stay in `ov7670_capture`.

## Test plan
- `SKIP_FRAMES` = 2, init high, 4 good 640×480 frames → no `sys_we` in frames 1–2. Frames 3–4 each give exactly 307200 strobes, 4 `frame_valid` windows total minus 2 (2 windows), `frame_err` never asserted.
- Bytes 8'hF8, 8'h1F on one pixel → `sys_data_in` = 16'hF81F, `sys_we` high for 1 cycle, 2 cycles after the second byte.
- Line 100 carries 639 pixels → 639 strobes on that line, `frame_err` pulses once when `frame_valid` falls; the next good frame has no error.
- Frame of 481 lines → 307200 strobes (line 481 suppressed), `frame_err` = 1.
- Init high during mid-frame VSYNC low → no strobes until the next `vs_fall`.
- `sdram_init_done` dropped at pixel 1000 → `frame_valid` = 0 next cycle, no further `sys_we`, no `frame_err`. After re-assertion, the skip sequence repeats.
- `rst_n` asserted mid-line, asynchronously → all outputs go to 0 immediately.
